// File: rtl/reg_pkg.sv
// Shared definitions for the register-file writeback slice.
//   DATA_W / ADDR_W / NUM_REGS : geometry of the 8x16 register file
//   reg_addr_t / reg_data_t    : register address and data types
//   wb_src_e                   : writeback source identifiers (ALU, LSU)
package reg_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_rr_arb.sv
// Two-requester round-robin arbiter (ALU vs LSU).
//   clk, rst_n        : clock, synchronous active-low reset
//   req_alu, req_lsu  : request lines
//   gnt_alu, gnt_lsu  : one-hot (or zero) combinational grants
// The pointer names the source that wins the next contended cycle. It only
// moves when both requesters are active, so a lone requester never
// disturbs the fairness order. Reset points it at the ALU.
module wb_rr_arb
  import reg_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_alu,
  input  logic req_lsu,
  output logic gnt_alu,
  output logic gnt_lsu
);

  wb_src_e ptr_q;
  logic    contended;

  assign contended = req_alu && req_lsu;

  always_comb begin
    gnt_alu = 1'b0;
    gnt_lsu = 1'b0;
    if (contended) begin
      gnt_alu = (ptr_q == SRC_ALU);
      gnt_lsu = (ptr_q == SRC_LSU);
    end else begin
      gnt_alu = req_alu;
      gnt_lsu = req_lsu;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= SRC_ALU;
    end else if (contended) begin
      ptr_q <= (ptr_q == SRC_ALU) ? SRC_LSU : SRC_ALU;
    end
  end

endmodule

// File: rtl/reg_wb_sequencer.sv
// Write-side controller for the 8x16 register file.
// Arbitrates ALU and LSU writeback requests, drives the register-file write
// port from a registered stage, and keeps a per-register outstanding-write
// scoreboard for RAW hazard detection at issue.
//
// Handshake: a source raises valid with addr/data and holds them stable
// until it sees ready; ready is high only in the cycle that source is
// granted (ready depends on valid, never the reverse). The accepted write
// appears on wr_en/wr0_addr/wr0_data in the following cycle.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   iss_valid, iss_addr, iss_stall  write reservation from issue stage
//   alu_valid/addr/data, alu_ready  ALU writeback request
//   lsu_valid/addr/data, lsu_ready  LSU writeback request
//   wr_en, wr0_addr, wr0_data       register-file write port
//   pend_mask                       bit i set while register i has writes pending
//   err_underflow                   sticky: commit to a register with no reservation
//
// Build option WB_R0_ZERO_EN: register 0 is hardwired to zero. Writes to it
// are accepted but never drive wr_en, and reservations of it are ignored.
module reg_wb_sequencer
  import reg_pkg::NUM_REGS;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                iss_valid,
  input  logic [ADDR_W-1:0]   iss_addr,
  output logic                iss_stall,
  input  logic                alu_valid,
  input  logic [ADDR_W-1:0]   alu_addr,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                alu_ready,
  input  logic                lsu_valid,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_data,
  output logic                lsu_ready,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr0_addr,
  output logic [DATA_W-1:0]   wr0_data,
  output logic [NUM_REGS-1:0] pend_mask,
  output logic                err_underflow
);

`ifdef WB_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  // ---------------- arbitration ----------------
  logic              gnt_alu;
  logic              gnt_lsu;
  logic              gnt_any;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  wb_rr_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_alu (alu_valid),
    .req_lsu (lsu_valid),
    .gnt_alu (gnt_alu),
    .gnt_lsu (gnt_lsu)
  );

  // Requests presented during reset are dropped, so ready stays low.
  assign alu_ready = rst_n && gnt_alu;
  assign lsu_ready = rst_n && gnt_lsu;
  assign gnt_any   = gnt_alu || gnt_lsu;
  assign sel_addr  = gnt_lsu ? lsu_addr : alu_addr;
  assign sel_data  = gnt_lsu ? lsu_data : alu_data;

  // ---------------- output stage ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en    <= 1'b0;
      wr0_addr <= '0;
      wr0_data <= '0;
    end else begin
      wr_en <= gnt_any && !(R0_ZERO && (sel_addr == '0));
      if (gnt_any) begin
        wr0_addr <= sel_addr;
        wr0_data <= sel_data;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [CNT_W-1:0]    cnt_vec [NUM_REGS];
  logic [NUM_REGS-1:0] under_vec;
  logic                iss_commit_hit;

  // A commit to the same register this cycle frees a slot, so a saturated
  // counter can still accept the reservation (net change zero).
  assign iss_commit_hit = wr_en && (wr0_addr == iss_addr);
  assign iss_stall      = iss_valid
                          && (cnt_vec[iss_addr] == {CNT_W{1'b1}})
                          && !iss_commit_hit
                          && !(R0_ZERO && (iss_addr == '0));

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    logic             inc;
    logic             dec;

    assign inc = iss_valid && (iss_addr == ADDR_W'(i)) && !iss_stall
                 && !(R0_ZERO && (i == 0));
    assign dec = wr_en && (wr0_addr == ADDR_W'(i));

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (inc && !dec) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (dec && !inc && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end

    assign cnt_vec[i]   = cnt_q;
    assign under_vec[i] = dec && !inc && (cnt_q == '0);
    assign pend_mask[i] = (cnt_q != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_underflow <= 1'b0;
    end else if (|under_vec) begin
      err_underflow <= 1'b1;
    end
  end

endmodule

// File: doc/reg_wb_sequencer.md
Name: reg_wb_sequencer

Overview:
- Write-side controller for the 8x16 register file.
- Takes writeback requests from the ALU and the load/store unit (LSU) on valid/ready handshakes and arbitrates between them round-robin.
- Drives the register file write port (wr_en, wr0_addr, wr0_data) from a registered output stage.
- Keeps a per-register pending-write scoreboard so the issue stage can detect RAW hazards before reading operands.

Parameters:
- DATA_W, 16, register data width.
- ADDR_W, 3, register address width (8 registers).
- CNT_W, 2, width of each register's outstanding-write counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- iss_valid  in  1  issue stage reserves a write to iss_addr.
- iss_addr  in  ADDR_W  destination register being reserved.
- iss_stall  out  1  reservation refused; counter for iss_addr is saturated.
- alu_valid  in  1  ALU writeback request.
- alu_addr  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU request accepted this cycle.
- lsu_valid  in  1  LSU writeback request.
- lsu_addr  in  ADDR_W  LSU destination register.
- lsu_data  in  DATA_W  load data.
- lsu_ready  out  1  LSU request accepted this cycle.
- wr_en  out  1  register file write enable.
- wr0_addr  out  ADDR_W  register file write address.
- wr0_data  out  DATA_W  register file write data.
- pend_mask  out  8  bit i = 1 when counter i != 0.
- err_underflow  out  1  sticky flag: a write committed to a register with counter 0.

Behaviour:
- Reset is synchronous (rst_n low at a clk edge). Reset values:
  - wr_en = 0, wr0_addr = 0, wr0_data = 0.
  - All counters = 0, so pend_mask = 0.
  - err_underflow = 0.
  - Round-robin pointer = ALU.
  - alu_ready and lsu_ready are low while rst_n is low.
- Reset mid-operation drops any request not yet registered. A write already presented on wr_en in that cycle still reaches the register file; the register file has no reset.
- Arbitration is combinational and grants at most one request per cycle:
  - Only one source valid: that source is granted.
  - Both valid: the source named by the pointer is granted, and the pointer moves to the other source.
  - Pointer updates only on a contended grant.
  - A source's ready is high only in the cycle it is granted. A source must hold valid, addr and data stable until it sees ready.
  - ready depends on valid; sources must not gate valid on ready.
- Output stage latency is 1 cycle:
  - A request granted in cycle N appears on wr_en=1, wr0_addr and wr0_data in cycle N+1.
  - wr_en = 0 in any cycle following a cycle with no grant.
  - Back-to-back grants give back-to-back writes, so throughput is 1 write per cycle.
- Scoreboard (one counter per register):
  - Increment on an accepted iss_valid.
  - Decrement on commit, i.e. the cycle wr_en=1 with wr0_addr = that register.
  - Issue and commit to the same register in the same cycle: counter unchanged.
- Saturation:
  - iss_stall = iss_valid and counter[iss_addr] == all-ones, and no commit to iss_addr this cycle.
  - A stalled issue does not increment.
- Underflow:
  - A commit to a register whose counter is 0 (and no same-cycle issue) still performs the write.
  - The counter stays 0 and err_underflow sets. Only reset clears it.
- pend_mask is a registered view of the counters: it reflects counter state after the clock edge.

Optional Feature:
- Macro WB_R0_ZERO_EN.
- Defined: register 0 is hardwired to zero.
  - Requests to address 0 are still granted (ready returned) but produce no wr_en.
  - Issues to address 0 never increment; iss_stall is never raised for address 0.
  - pend_mask[0] stays 0.
- Undefined: register 0 behaves like every other register.

Decomposition:
- Shared package reg_pkg:
  - DATA_W, ADDR_W, NUM_REGS = 8.
  - Typedef reg_addr_t and reg_data_t.
  - Enum wb_src_e {SRC_ALU, SRC_LSU}.
- One sub-module: wb_rr_arb, a 2-requester round-robin arbiter with pointer register, grant outputs and a contention-update rule.
- Scoreboard counters stay inline, generated over NUM_REGS.

Test Plan:
- ALU only, alu_addr=3, alu_data=16'h1234 for 1 cycle -> alu_ready same cycle; next cycle wr_en=1, wr0_addr=3, wr0_data=16'h1234; following cycle wr_en=0.
- ALU (r1, 16'hAAAA) and LSU (r2, 16'h5555) valid for 4 cycles after reset -> grants alternate ALU, LSU, ALU, LSU; writes appear one cycle later in the same order.
- iss_valid to r5 three times with no commits -> counter 3, pend_mask=8'h20; fourth issue gives iss_stall=1 and counter stays 3.
- r4 counter 1; issue r4 in the same cycle as a commit to r4 -> counter stays 1, pend_mask[4]=1, no stall.
- Commit to r6 with counter 0 -> write performed, err_underflow=1 and remains 1 until rst_n=0 for one edge.
- WB_R0_ZERO_EN defined: ALU write to r0 -> alu_ready=1, wr_en stays 0; iss_valid to r0 -> pend_mask[0]=0.
